// File: rtl/seq_multiplier_if.sv
// Start/done handshake and operand/result bus for seq_multiplier.
// Latency: none (wires only).
// Backpressure: none; the requester must wait for done and then for busy to be low before the next start.
// Signals: start, a, b (requester -> multiplier); busy, done, product (multiplier -> requester).
// Modports: master (requester side), slave (multiplier side).
interface seq_multiplier_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/seq_multiplier.sv
// Sequential shift-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH, one shared 2*WIDTH-bit adder.
// Latency: done pulses in the cycle after edge T+WIDTH for a start accepted at edge T
//          (with SEQ_MULT_EARLY_TERM_EN: position of b's highest set bit + 1 RUN cycles, minimum 1).
// Backpressure: start is sampled only in IDLE; start during RUN/DONE is dropped, never queued.
// Ports: clk (rising edge), rst_n (async active-low),
//        bus.slave: start/a/b in; busy (state RUN), done (one-cycle pulse), product (held until next completion) out.
// Optional macro: SEQ_MULT_EARLY_TERM_EN ends the run once no multiplier bits remain set.
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_multiplier_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [PW-1:0]     r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [PW-1:0]     r_acc;
    logic [CNT_W-1:0]  r_count;
    logic [PW-1:0]     r_product;

    logic [PW-1:0]     w_sum;
    logic [WIDTH-1:0]  w_mplier_shr;
    logic              w_accept;
    logic              w_last;

    // One add per RUN cycle; the partial product is skipped when the current multiplier bit is 0.
    assign w_sum        = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mplier_shr = r_mplier >> 1;
    assign w_accept     = (r_state == S_IDLE) && bus.start;

`ifdef SEQ_MULT_EARLY_TERM_EN
    // Once the shifted multiplier is empty no further add can change acc, so stop here;
    // count still caps the run at WIDTH cycles.
    assign w_last = (r_count == CNT_W'(1)) || (w_mplier_shr == '0);
`else
    assign w_last = (r_count == CNT_W'(1));
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = bus.start ? S_RUN : S_IDLE;
            S_RUN:   w_state_nxt = w_last ? S_DONE : S_RUN;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are pure decodes of the state register, so they cannot glitch.
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (r_state)
            S_RUN:   bus.busy = 1'b1;
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

    // Datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, bus.a};
            r_mplier <= bus.b;
            r_acc    <= '0;
            r_count  <= CNT_W'(WIDTH);
        end else if (r_state == S_RUN) begin
            r_acc    <= w_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_shr;
            r_count  <= r_count - CNT_W'(1);
            // product only moves on the edge entering DONE, and includes this edge's add.
            if (w_last) begin
                r_product <= w_sum;
            end
        end
    end

    assign bus.product = r_product;

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    seq_multiplier_if #(.WIDTH(4)) if4 ();
    seq_multiplier_if #(.WIDTH(8)) if8 ();

    seq_multiplier #(.WIDTH(4)) u_mul4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    seq_multiplier #(.WIDTH(8)) u_mul8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference latency: the operand width, or with early termination the
    // index of b's top set bit + 1 (at least one cycle).
    function automatic int exp_lat(input int width, input int b);
`ifdef SEQ_MULT_EARLY_TERM_EN
        int msb = 0;
        for (int i = 0; i < width; i++) begin
            if (b[i]) msb = i + 1;
        end
        return (msb == 0) ? 1 : msb;
`else
        return width + (b & 0);
`endif
    endfunction

    function automatic logic obs_busy(input bit sel);
        return sel ? if8.busy : if4.busy;
    endfunction

    function automatic logic obs_done(input bit sel);
        return sel ? if8.done : if4.done;
    endfunction

    function automatic logic [15:0] obs_prod(input bit sel);
        return sel ? if8.product : {8'h00, if4.product};
    endfunction

    task automatic drive(input bit sel, input logic st, input logic [7:0] a, input logic [7:0] b);
        if (sel) begin
            if8.start = st; if8.a = a; if8.b = b;
        end else begin
            if4.start = st; if4.a = a[3:0]; if4.b = b[3:0];
        end
    endtask

    // One full transaction with latency, hold, pulse-width and result checks.
    task automatic do_op(input bit sel, input int a, input int b, input string tag);
        int          w;
        int          busy_cnt;
        int          cyc;
        bit          hold_bad;
        logic [15:0] prev;
        logic [15:0] exp_p;
        w     = sel ? 8 : 4;
        exp_p = 16'(a * b);
        @(negedge clk);
        prev = obs_prod(sel);
        drive(sel, 1'b1, 8'(a), 8'(b));
        @(negedge clk);
        // Scramble operands after the accept edge; they must not matter.
        drive(sel, 1'b0, 8'($urandom), 8'($urandom));
        busy_cnt = 0;
        cyc      = 0;
        hold_bad = 0;
        while (!obs_done(sel) && cyc < 40) begin
            if (obs_busy(sel)) busy_cnt++;
            if (obs_prod(sel) !== prev) hold_bad = 1;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_seen"}, 32'(obs_done(sel)), 32'd1);
        check({tag, "_product"},   32'(obs_prod(sel)), 32'(exp_p));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat(w, b)));
        check({tag, "_busy_at_done"}, 32'(obs_busy(sel)), 32'd0);
        check({tag, "_product_hold"}, 32'(hold_bad), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse_width"}, 32'(obs_done(sel)), 32'd0);
        check({tag, "_product_stable"}, 32'(obs_prod(sel)), 32'(exp_p));
    endtask

    initial begin
        int dones;
        int a_r;
        int b_r;

        rst_n = 1'b0;
        drive(0, 1'b0, 8'd0, 8'd0);
        drive(1, 1'b0, 8'd0, 8'd0);
        repeat (3) @(negedge clk);
        check("reset_busy4", 32'(if4.busy), 32'd0);
        check("reset_done4", 32'(if4.done), 32'd0);
        check("reset_prod4", 32'(if4.product), 32'd0);
        check("reset_busy8", 32'(if8.busy), 32'd0);
        check("reset_prod8", 32'(if8.product), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Maximum operands and zero operands.
        do_op(0, 15, 15, "w4_max");
        do_op(0, 9, 0, "w4_b_zero");
        do_op(0, 0, 13, "w4_a_zero");

        // start re-asserted during RUN must be ignored.
        @(negedge clk);
        drive(0, 1'b1, 8'd3, 8'd5);
        @(negedge clk);
        drive(0, 1'b1, 8'd7, 8'd7);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) drive(0, 1'b0, 8'd7, 8'd7);
            if (if4.done) dones++;
            @(negedge clk);
        end
        check("w4_ignore_start_dones", 32'(dones), 32'd1);
        check("w4_ignore_start_prod", 32'(if4.product), 32'd15);
        do_op(0, 7, 7, "w4_after_ignore");

        // Reset in the middle of a run aborts without a done pulse.
        @(negedge clk);
        drive(0, 1'b1, 8'd6, 8'd7);
        @(negedge clk);
        drive(0, 1'b0, 8'd0, 8'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(if4.busy), 32'd0);
        check("abort_done", 32'(if4.done), 32'd0);
        check("abort_prod", 32'(if4.product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (if4.done || if4.busy) dones++;
            @(negedge clk);
        end
        check("abort_no_activity", 32'(dones), 32'd0);
        check("abort_prod_after", 32'(if4.product), 32'd0);

        // Wide instance: max operands and early-termination patterns.
        do_op(1, 255, 255, "w8_max");
        do_op(1, 200, 3, "w8_b3");
        do_op(1, 200, 128, "w8_b128");
        do_op(1, 77, 0, "w8_b_zero");

        // Random sweep against a*b.
        for (int n = 0; n < 1000; n++) begin
            a_r = int'($urandom_range(0, 255));
            b_r = int'($urandom_range(0, 255));
            do_op(1, a_r, b_r, "w8_rand");
        end
        for (int n = 0; n < 50; n++) begin
            a_r = int'($urandom_range(0, 15));
            b_r = int'($urandom_range(0, 15));
            do_op(0, a_r, b_r, "w4_rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
